// File: rtl/piso_frame_tx.sv
// Parallel-in, serial-out framed transmitter: start bit, LSB-first data,
// optional even parity, stop bit; each bit held for BAUD_DIV clocks.
module piso_frame_tx #(
  parameter int DATA_W    = 8,
  parameter int BAUD_DIV  = 1,
  parameter int PARITY_EN = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              sout,
  output logic              busy,
  output logic              done
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [IW-1:0]     idx, idx_n;
  logic [DATA_W-1:0] shift_reg, shift_n;
  logic              par, par_n;
  logic              bit_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift_reg <= '0;
      par       <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      shift_reg <= shift_n;
      par       <= par_n;
    end
  end

  // Parity is captured at acceptance because the data bits are shifted out
  // of shift_reg before the parity bit goes on the line.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = idx;
    shift_n  = shift_reg;
    par_n    = par;
    bit_end  = (cnt == CNT_LAST);
    sout     = 1'b1;
    tx_ready = 1'b0;
    done     = 1'b0;

    if (state != IDLE)
      cnt_n = bit_end ? '0 : cnt + CW'(1);

    unique case (state)
      IDLE: begin
        tx_ready = 1'b1;
        cnt_n    = '0;
        idx_n    = '0;
        if (tx_valid) begin
          shift_n = tx_data;
          par_n   = ^tx_data;
          state_n = START;
        end
      end
      START: begin
        sout = 1'b0;
        if (bit_end) state_n = DATA;
      end
      DATA: begin
        sout = shift_reg[0];
        if (bit_end) begin
          shift_n = shift_reg >> 1;
          if (idx == IDX_LAST) begin
            idx_n   = '0;
            state_n = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            idx_n = idx + IW'(1);
          end
        end
      end
      PARITY: begin
        sout = par;
        if (bit_end) state_n = STOP;
      end
      STOP: begin
        sout = 1'b1;
        if (bit_end) begin
          done    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    busy = !tx_ready;
  end

endmodule

// File: tb/tb_piso_frame_tx.sv
// Scoreboarded bench for piso_frame_tx over three configurations:
// plain (BAUD_DIV=1), divided (BAUD_DIV=4) and even parity (PARITY_EN=1).
module tb_piso_frame_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst_v;
  logic [2:0] tx_valid;
  logic [7:0] tx_data [3];
  logic [2:0] tx_ready, sout, busy, done;

  int n_cmp = 0;
  int n_err = 0;

  bit q [3][$];
  bit exp_rdy [3];
  bit armed [3];
  int acc_cnt [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    piso_frame_tx #(
      .DATA_W(8), .BAUD_DIV((g == 1) ? 4 : 1), .PARITY_EN((g == 2) ? 1 : 0)
    ) u_dut (
      .clk(clk), .rst(rst_v[g]), .tx_data(tx_data[g]), .tx_valid(tx_valid[g]),
      .tx_ready(tx_ready[g]), .sout(sout[g]), .busy(busy[g]), .done(done[g])
    );
  end

  function automatic int bd_of(input int i);
    return (i == 1) ? 4 : 1;
  endfunction

  function automatic int pe_of(input int i);
    return (i == 2) ? 1 : 0;
  endfunction

  task automatic chk(input string nm, input int i, input logic act, input bit exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d t=%0t: got %b expected %b", nm, i, $time, act, exp);
    end
  endtask

  // Reference model: on acceptance, the whole frame is laid out as a list of
  // per-cycle line levels; reset discards whatever is still pending.
  initial forever begin
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      logic [7:0] w;
      int nbits;
      bit b;
      if (rst_v[i] === 1'b1) begin
        q[i].delete();
        armed[i] = 1'b1;
      end else if (armed[i] && exp_rdy[i] && tx_valid[i] === 1'b1) begin
        w = tx_data[i];
        nbits = 10 + pe_of(i);
        for (int k = 0; k < nbits; k++) begin
          if (k == 0)                      b = 1'b0;
          else if (k <= 8)                 b = w[k-1];
          else if (k == 9 && pe_of(i) == 1) b = ^w;
          else                             b = 1'b1;
          repeat (bd_of(i)) q[i].push_back(b);
        end
        acc_cnt[i]++;
      end
    end
  end

  // Monitor: every cycle, pop the expected line level of a frame in flight
  // or expect idle, and compare all four outputs.
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      bit es, er, ed;
      if (armed[i]) begin
        if (q[i].size() > 0) begin
          es = q[i].pop_front();
          er = 1'b0;
          ed = (q[i].size() == 0);
        end else begin
          es = 1'b1;
          er = 1'b1;
          ed = 1'b0;
        end
        exp_rdy[i] = er;
        chk("sout", i, sout[i], es);
        chk("tx_ready", i, tx_ready[i], er);
        chk("busy", i, busy[i], !er);
        chk("done", i, done[i], ed);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int i);
    int c0;
    int n;
    c0 = acc_cnt[i];
    n = 0;
    while (acc_cnt[i] == c0 && n < 400) begin
      step();
      n++;
    end
    n_cmp++;
    if (acc_cnt[i] == c0) begin
      n_err++;
      $display("FAIL accept_timeout inst%0d t=%0t: got no acceptance expected one within 400 cycles", i, $time);
    end
  endtask

  task automatic send(input int i, input logic [7:0] w);
    tx_valid[i] = 1'b1;
    tx_data[i]  = w;
    wait_acc(i);
    tx_valid[i] = 1'b0;
    tx_data[i]  = 8'($urandom);
  endtask

  task automatic run(input int i);
    int flen;
    flen = (10 + pe_of(i)) * bd_of(i);
    // reset held with a word offered: nothing may start
    rst_v[i] = 1'b1;
    tx_valid[i] = 1'b1;
    tx_data[i] = 8'h5A;
    repeat (2) step();
    rst_v[i] = 1'b0;
    tx_valid[i] = 1'b0;
    repeat (2) step();

    send(i, 8'hA5);
    send(i, 8'h3C);
    send(i, 8'h07);
    send(i, 8'hA5);
    repeat (flen + 2) step();

    // back-to-back with tx_data disturbed while the first frame is on the line
    tx_valid[i] = 1'b1;
    tx_data[i] = 8'h01;
    wait_acc(i);
    tx_data[i] = 8'h3E;
    repeat (3) step();
    tx_data[i] = 8'hFF;
    wait_acc(i);
    tx_valid[i] = 1'b0;
    tx_data[i] = 8'h00;
    repeat (flen + 2) step();

    // reset during data bit 3 of 0x55
    send(i, 8'h55);
    repeat (4 * bd_of(i)) step();
    rst_v[i] = 1'b1;
    step();
    rst_v[i] = 1'b0;
    repeat (2) step();
    send(i, 8'h81);

    for (int n = 0; n < 24; n++) begin
      repeat ($urandom_range(0, 3)) step();
      send(i, 8'($urandom));
      if ($urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(0, flen)) step();
        rst_v[i] = 1'b1;
        step();
        rst_v[i] = 1'b0;
      end
    end
    repeat (flen + 4) step();
  endtask

  initial begin
    rst_v = '0;
    tx_valid = '0;
    for (int i = 0; i < 3; i++) begin
      tx_data[i] = 8'h00;
      exp_rdy[i] = 1'b0;
      armed[i] = 1'b0;
      acc_cnt[i] = 0;
    end
    fork
      run(0);
      run(1);
      run(2);
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog t=%0t: got no end of run expected completion", $time);
    $fatal(1);
  end

endmodule

// File: doc/piso_frame_tx.md
# piso_frame_tx

Parallel-in, serial-out framed transmitter: the driving end of the team's serial shift-register link. It accepts a parallel word through a valid/ready handshake and latches it. It then shifts the word out LSB-first on a single line, framed by a start bit, an optional even-parity bit and a stop bit. Each bit is held for a programmable number of clock cycles. It sits between a parallel producer (register bank or FIFO) and the serial receive shift register on the far end.

## Interface
Parameters:
- DATA_W, 8, payload width in bits (≥1)
- BAUD_DIV, 1, clock cycles per serial bit (≥1)
- PARITY_EN, 0, 1 = insert even-parity bit after the data bits

Ports:
- clk  input  1  single clock; all logic is on the rising edge
- rst  input  1  synchronous, active-high reset
- tx_data  input  DATA_W  word to send; sampled only at acceptance
- tx_valid  input  1  producer has a word
- tx_ready  output  1  block can accept a word
- sout  output  1  serial line; idles high
- busy  output  1  a frame is in progress
- done  output  1  one-cycle pulse in the last cycle of the stop bit

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE: sout=1, busy=0, tx_ready=1.
  - START: sout=0.
  - DATA: sout=shift_reg[0]; the register shifts right at each bit boundary.
  - PARITY: sout = XOR of all latched data bits.
  - STOP: sout=1.
- Acceptance:
  - A rising edge with tx_valid=1 and tx_ready=1 latches tx_data into shift_reg.
  - On the same edge the state moves IDLE→START, the bit-cycle counter clears and the bit index clears.
- Bit timing:
  - A bit-cycle counter of width clog2(BAUD_DIV), minimum 1, counts 0..BAUD_DIV-1 within each bit.
  - The state or bit advances when the counter reaches BAUD_DIV-1.
  - With BAUD_DIV=1 the counter is effectively constant and every bit lasts one cycle.
- Data bits:
  - Transmitted d0 first, d(DATA_W-1) last.
  - A bit index counts 0..DATA_W-1.
  - After the last data bit the state goes to PARITY if PARITY_EN=1, otherwise to STOP.
- STOP→IDLE at the end of the stop bit; done=1 during the final stop-bit cycle only.
- tx_ready=0 in every non-IDLE state. tx_valid and tx_data are ignored while busy.
- Parity is computed from the latched word, not the live tx_data.
- Reset (synchronous) forces on the next edge:
  - outputs: sout=1, busy=0, tx_ready=1, done=0
  - internal: state=IDLE, counters=0, shift_reg=0
- Reset asserted mid-frame aborts the frame: no done pulse, and the partial word is discarded.
- Reset has priority over acceptance in the same cycle.

## Timing
- Reset values: sout=1, tx_ready=1, busy=0, done=0.
- Latency: acceptance edge E0 → sout=0 (start bit) in the cycle after E0.
- Frame length: (2 + DATA_W + PARITY_EN) × BAUD_DIV cycles, counted from the cycle after E0 through the last stop cycle.
- Bit k of the frame (k=0 is the start bit) occupies cycles E0+1+k·BAUD_DIV … E0+(k+1)·BAUD_DIV.
- done is high in cycle E0 + (2+DATA_W+PARITY_EN)·BAUD_DIV. The next cycle is IDLE with tx_ready=1.
- Back-to-back operation with tx_valid held high:
  - Exactly one IDLE cycle (sout=1) separates the stop bit of frame N from the start bit of frame N+1.
  - The second word is accepted at the end of that IDLE cycle.
- busy = !tx_ready at all times. It is registered, with no combinational path from tx_valid.

## Test plan
- Reset: assert rst for 2 cycles with tx_valid=1 → sout=1, tx_ready=1, busy=0, done=0 throughout; no frame starts until rst is released.
- Basic frame (DATA_W=8, BAUD_DIV=1, PARITY_EN=0), send 0xA5 → sout = 0,1,0,1,0,0,1,0,1,1 over 10 cycles starting the cycle after acceptance; done high in cycle 10; tx_ready high in cycle 11.
- Divider (BAUD_DIV=4), send 0x3C → each bit held exactly 4 cycles; 40-cycle frame; data portion 0,0,1,1,1,1,0,0, each bit ×4.
- Parity (PARITY_EN=1, BAUD_DIV=1):
  - send 0x07 → parity bit = 1, 11-cycle frame
  - send 0xA5 → parity bit = 0
- Back-to-back: send 0x01, then 0xFF with tx_valid held; change tx_data mid-frame → first frame unaffected; exactly one sout=1 IDLE cycle between frames; second frame carries 0xFF.
- Mid-frame reset: assert rst during data bit 3 of 0x55 → next cycle sout=1, tx_ready=1, no done pulse; a fresh 0x81 then transmits correctly.
